rbz_spi_cfg_sched: RTL and testbench

SPI-driven configuration scheduler for the raybox-zero renderer. Receives command frames from an external SPI master on asynchronous pins, holds each decoded update in a pending shadow register, and commits all pending updates atomically to the live view registers at the start of vertical blanking. A frame therefore never renders with a half-updated view. Sits between the top-level `ui_in` SPI pins and the rbzero tracer/renderer, which consume the live outputs.

---
 rtl/rbz_spi_cfg_sched.sv | 184 ++++++++++++++++++
 tb/tb_rbz_spi_cfg_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rbz_spi_cfg_sched.sv
// SPI command receiver with per-group shadow registers that commit atomically
// to the live raybox-zero view registers on the rising edge of vblank.
module rbz_spi_cfg_sched #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_sclk,
  input  logic         i_mosi,
  input  logic         i_ss_n,
  input  logic         i_vblank,
  output logic [W-1:0] o_px,
  output logic [W-1:0] o_py,
  output logic [W-1:0] o_fx,
  output logic [W-1:0] o_fy,
  output logic [W-1:0] o_vx,
  output logic [W-1:0] o_vy,
  output logic [5:0]   o_sky,
  output logic [5:0]   o_floor,
  output logic         o_pending,
  output logic         o_commit
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_DRAIN} state_t;

  typedef struct packed {
    logic [W-1:0] px, py, fx, fy, vx, vy;
    logic [5:0]   sky, floor;
  } view_t;

  localparam view_t RST_VIEW = {W'(16'h0580), W'(16'h0B00), W'(16'h0000),
                                W'(16'hC000), W'(16'h2000), W'(16'h0000),
                                6'b010101, 6'b101010};

  localparam int            CW       = $clog2(2 * W);
  localparam logic [CW-1:0] LAST_CMD = CW'(3);
  localparam logic [CW-1:0] LAST_VEC = CW'(2 * W - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(11);

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_mosi_s1, r_mosi_s2;
  logic r_ss_s1, r_ss_s2;

  // NOTE: non-blocking assignments make every flop sample the previous stage's
  // old value, so the chain really is two stages deep regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_ss_s1   <= i_ss_n;
      r_ss_s2   <= r_ss_s1;
    end
  end

  logic w_rise;
  logic w_bit;
  assign w_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_bit  = r_mosi_s2;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cmd;
  logic [3:0]      w_cmd_full;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_len_m1;
  logic [2*W-1:0]  r_shift;
  logic            w_last;
  logic            r_done;

  assign w_cmd_full = {r_cmd[2:0], w_bit};
  assign w_len_m1   = (r_cmd == 4'd3) ? LAST_COL : LAST_VEC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE:    if (!r_ss_s2) w_state_nxt = S_CMD;
      S_CMD:     if (w_rise && r_cnt == LAST_CMD)
                   w_state_nxt = (w_cmd_full[3:2] == 2'b00) ? S_PAYLOAD : S_DRAIN;
      S_PAYLOAD: if (w_rise && r_cnt == w_len_m1) begin
                   w_state_nxt = S_DRAIN;
                   w_last      = 1'b1;
                 end
      default:   w_state_nxt = r_state;
    endcase
    // Deselect wins over everything: a partial frame is simply dropped.
    if (r_ss_s2) begin
      w_state_nxt = S_IDLE;
      w_last      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (w_rise && r_state == S_CMD) begin
        r_cmd <= w_cmd_full;
        r_cnt <= (r_cnt == LAST_CMD) ? '0 : r_cnt + CW'(1);
      end else if (w_rise && r_state == S_PAYLOAD) begin
        r_shift <= {r_shift[2*W-2:0], w_bit};
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  logic       r_vblank_d;
  logic [3:0] r_flags, w_flags_nxt;
  logic       w_commit_edge;
  view_t      r_shadow, r_live;

  assign w_commit_edge = i_vblank & ~r_vblank_d;

  // A write landing on the commit edge sets its flag after the clear.
  always_comb begin
    w_flags_nxt = w_commit_edge ? 4'b0000 : r_flags;
    if (r_done) w_flags_nxt[r_cmd[1:0]] = 1'b1;
  end

  // NOTE: shadow and live registers are reset to a usable view so the
  // renderer draws a sane frame before any SPI traffic arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank_d <= 1'b0;
      r_flags    <= 4'b0000;
      r_shadow   <= RST_VIEW;
      r_live     <= RST_VIEW;
      o_pending  <= 1'b0;
      o_commit   <= 1'b0;
    end else begin
      r_vblank_d <= i_vblank;
      r_flags    <= w_flags_nxt;
      o_pending  <= |w_flags_nxt;
      o_commit   <= w_commit_edge & (|r_flags);
      if (r_done) begin
        case (r_cmd[1:0])
          2'd0: begin r_shadow.px <= r_shift[2*W-1 -: W]; r_shadow.py <= r_shift[W-1:0]; end
          2'd1: begin r_shadow.fx <= r_shift[2*W-1 -: W]; r_shadow.fy <= r_shift[W-1:0]; end
          2'd2: begin r_shadow.vx <= r_shift[2*W-1 -: W]; r_shadow.vy <= r_shift[W-1:0]; end
          default: begin r_shadow.sky <= r_shift[11:6]; r_shadow.floor <= r_shift[5:0]; end
        endcase
      end
      if (w_commit_edge) begin
        if (r_flags[0]) begin r_live.px <= r_shadow.px; r_live.py <= r_shadow.py; end
        if (r_flags[1]) begin r_live.fx <= r_shadow.fx; r_live.fy <= r_shadow.fy; end
        if (r_flags[2]) begin r_live.vx <= r_shadow.vx; r_live.vy <= r_shadow.vy; end
        if (r_flags[3]) begin r_live.sky <= r_shadow.sky; r_live.floor <= r_shadow.floor; end
      end
    end
  end

  assign o_px    = r_live.px;
  assign o_py    = r_live.py;
  assign o_fx    = r_live.fx;
  assign o_fy    = r_live.fy;
  assign o_vx    = r_live.vx;
  assign o_vy    = r_live.vy;
  assign o_sky   = r_live.sky;
  assign o_floor = r_live.floor;

endmodule

// File: tb/tb_rbz_spi_cfg_sched.sv
// Self-checking bench for rbz_spi_cfg_sched: table of SPI frames plus hand-written
// corner sequences, with a reference view model feeding a commit scoreboard.
module tb_rbz_spi_cfg_sched;

  typedef struct packed {
    logic [15:0] px, py, fx, fy, vx, vy;
    logic [5:0]  sky, floor;
  } view_t;

  typedef struct packed {
    view_t view;
    logic  commit;
  } exp_t;

  typedef struct {
    logic [63:0] frame;
    int          nbits;
    logic        exp_pend;
    string       name;
  } vec_t;

  localparam view_t RST_VIEW = {16'h0580, 16'h0B00, 16'h0000, 16'hC000,
                                16'h2000, 16'h0000, 6'b010101, 6'b101010};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sclk = 1'b0, i_mosi = 1'b0, i_ss_n = 1'b1, i_vblank = 1'b0;
  logic [15:0] o_px, o_py, o_fx, o_fy, o_vx, o_vy;
  logic [5:0]  o_sky, o_floor;
  logic        o_pending, o_commit;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int m_pulses = 0;

  view_t m_live, m_shadow;
  logic [3:0] m_pend;
  exp_t  sb_q[$];
  vec_t  vecs[6];

  always #5 clk = ~clk;

  rbz_spi_cfg_sched #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sclk(i_sclk), .i_mosi(i_mosi), .i_ss_n(i_ss_n), .i_vblank(i_vblank),
    .o_px(o_px), .o_py(o_py), .o_fx(o_fx), .o_fy(o_fy), .o_vx(o_vx), .o_vy(o_vy),
    .o_sky(o_sky), .o_floor(o_floor), .o_pending(o_pending), .o_commit(o_commit)
  );

  always @(negedge clk) if (rst_n && o_commit) n_pulses++;

  function automatic view_t dut_view();
    return {o_px, o_py, o_fx, o_fy, o_vx, o_vy, o_sky, o_floor};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_live   = RST_VIEW;
    m_shadow = RST_VIEW;
    m_pend   = 4'b0000;
  endtask

  // Reference decode: the first payload bits after the 4-bit command fill the group.
  task automatic model_write(input logic [63:0] frame, input int n);
    int np;
    logic [3:0]  c;
    logic [31:0] p;
    np = n - 4;
    if (np < 0) return;
    c = 4'((frame >> np) & 64'hF);
    if (c <= 4'd2 && np >= 32) begin
      p = 32'(frame >> (np - 32));
      case (c)
        4'd0: begin m_shadow.px = p[31:16]; m_shadow.py = p[15:0]; end
        4'd1: begin m_shadow.fx = p[31:16]; m_shadow.fy = p[15:0]; end
        default: begin m_shadow.vx = p[31:16]; m_shadow.vy = p[15:0]; end
      endcase
      m_pend[c[1:0]] = 1'b1;
    end else if (c == 4'd3 && np >= 12) begin
      p = 32'(frame >> (np - 12));
      m_shadow.sky   = p[11:6];
      m_shadow.floor = p[5:0];
      m_pend[3] = 1'b1;
    end
  endtask

  task automatic model_commit();
    exp_t e;
    e.commit = |m_pend;
    if (m_pend[0]) begin m_live.px = m_shadow.px; m_live.py = m_shadow.py; end
    if (m_pend[1]) begin m_live.fx = m_shadow.fx; m_live.fy = m_shadow.fy; end
    if (m_pend[2]) begin m_live.vx = m_shadow.vx; m_live.vy = m_shadow.vy; end
    if (m_pend[3]) begin m_live.sky = m_shadow.sky; m_live.floor = m_shadow.floor; end
    if (e.commit) m_pulses++;
    m_pend = 4'b0000;
    e.view = m_live;
    sb_q.push_back(e);
  endtask

  task automatic check_commit(input string name);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty, got view %h", name, dut_view());
      return;
    end
    n_checks--;
    e = sb_q.pop_front();
    check({name, "_view"}, 128'(dut_view()), 128'(e.view));
    check({name, "_commit"}, 128'(o_commit), 128'(e.commit));
  endtask

  // Bit-banged mode-0 frame; optionally raises vblank so the commit edge lands
  // on the same clk edge that writes this frame's shadow.
  task automatic send_frame(input logic [63:0] frame, input int n, input bit vb_on_last,
                            input string name);
    i_ss_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < n; i++) begin
      i_mosi = frame[n-1-i];
      wait_clks(4);
      i_sclk = 1'b1;
      if (vb_on_last && i == n - 1) begin
        wait_clks(3);
        i_vblank = 1'b1;
        model_commit();
        wait_clks(1);
        check_commit(name);
      end else begin
        wait_clks(4);
      end
      i_sclk = 1'b0;
    end
    wait_clks(4);
    i_ss_n = 1'b1;
    wait_clks(6);
    model_write(frame, n);
  endtask

  task automatic do_vblank(input string name);
    i_vblank = 1'b0;
    wait_clks(2);
    i_vblank = 1'b1;
    model_commit();
    wait_clks(1);
    check_commit(name);
    wait_clks(1);
    check({name, "_commit_one_cycle"}, 128'(o_commit), 128'(0));
    check({name, "_pending_clear"}, 128'(o_pending), 128'(0));
    wait_clks(3);
    i_vblank = 1'b0;
    wait_clks(2);
  endtask

  initial begin
    vecs[0] = '{{28'h0, 4'h0, 32'h1234_ABCD}, 36, 1'b1, "set_pos"};
    vecs[1] = '{{55'h0, 4'h3, 5'b10110},      9,  1'b0, "color_abort"};
    vecs[2] = '{{28'h0, 4'hF, 32'hDEAD_BEEF}, 36, 1'b0, "unknown_cmd"};
    vecs[3] = '{{44'h0, 4'h3, 6'h3F, 6'h00, 4'hA}, 20, 1'b1, "color_extra_bits"};
    vecs[4] = '{{28'h0, 4'h1, 32'h5A5A_0F0F}, 36, 1'b1, "set_facing"};
    vecs[5] = '{{48'h0, 4'h3, 6'h12, 6'h2D},  16, 1'b1, "set_color"};

    model_reset();
    wait_clks(3);
    check("reset_view", 128'(dut_view()), 128'(RST_VIEW));
    check("reset_pending", 128'(o_pending), 128'(0));
    rst_n = 1'b1;
    wait_clks(2);
    check("post_reset_view", 128'(dut_view()), 128'(RST_VIEW));
    check("post_reset_commit", 128'(o_commit), 128'(0));

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].frame, vecs[v].nbits, 1'b0, vecs[v].name);
      check({vecs[v].name, "_pending"}, 128'(o_pending), 128'(vecs[v].exp_pend));
      check({vecs[v].name, "_view_before_vblank"}, 128'(dut_view()), 128'(m_live));
      do_vblank(vecs[v].name);
    end

    // Last write to a group before the commit wins.
    send_frame({28'h0, 4'h2, 32'h1111_3333}, 36, 1'b0, "vplane_a");
    send_frame({28'h0, 4'h2, 32'h2222_4444}, 36, 1'b0, "vplane_b");
    check("vplane_pending", 128'(o_pending), 128'(1));
    do_vblank("vplane_last_wins");
    check("vplane_vx", 128'(o_vx), 128'(16'h2222));

    // Facing frame completes on the commit edge: colour commits now, facing next time.
    send_frame({48'h0, 4'h3, 6'h07, 6'h38}, 16, 1'b0, "color_pre");
    send_frame({28'h0, 4'h1, 32'h7777_8888}, 36, 1'b1, "facing_on_edge");
    check("facing_on_edge_fx_unchanged", 128'(o_fx), 128'(16'h5A5A));
    check("facing_on_edge_pending", 128'(o_pending), 128'(1));
    do_vblank("facing_next_vblank");
    check("facing_next_fx", 128'(o_fx), 128'(16'h7777));

    // Reset in the middle of a frame with a pending group discards everything.
    send_frame({28'h0, 4'h0, 32'h0102_0304}, 36, 1'b0, "pos_before_reset");
    i_ss_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 6; i++) begin
      i_mosi = i[0];
      wait_clks(4);
      i_sclk = 1'b1;
      wait_clks(4);
      i_sclk = 1'b0;
    end
    rst_n = 1'b0;
    i_ss_n = 1'b1;
    model_reset();
    wait_clks(2);
    check("midframe_reset_view", 128'(dut_view()), 128'(RST_VIEW));
    check("midframe_reset_pending", 128'(o_pending), 128'(0));
    rst_n = 1'b1;
    wait_clks(6);
    do_vblank("after_reset_vblank");

    check("commit_pulse_count", 128'(n_pulses), 128'(m_pulses));
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete, %0d errors so far", n_errors);
    $fatal(1, "timeout");
  end

endmodule
